// File: rtl/pc_ras_unit.sv
// Program counter with next-PC priority selection and a circular return-address stack.
// JAL pushes the return address, JR pops it, and a popped address that disagrees with jr_target raises a one-cycle pulse.
module pc_ras_unit #(
  parameter int unsigned          PC_W      = 32,
  parameter logic [PC_W-1:0]      RESET_PC  = 32'h0000_0000,
  parameter int unsigned          INC       = 4,
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           pc_en,
  input  logic                           redirect,
  input  logic [PC_W-1:0]                redirect_target,
  input  logic                           branch_taken,
  input  logic [PC_W-1:0]                branch_target,
  input  logic                           jump,
  input  logic                           jal,
  input  logic [PC_W-1:0]                jump_target,
  input  logic                           jr,
  input  logic [PC_W-1:0]                jr_target,
  output logic [PC_W-1:0]                pc_curr,
  output logic [PC_W-1:0]                pc_next,
  output logic [PC_W-1:0]                pc_plus_inc,
  output logic [PC_W-1:0]                ras_top,
  output logic                           ras_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_mispredict
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH+1);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;       // next free slot; on a full stack it holds the oldest entry
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic [PTR_W-1:0] top_idx;
  logic             do_push, do_pop;

  assign pc_plus_inc = pc_q + PC_W'(INC);
  assign top_idx     = sp_q - PTR_W'(1);
  assign ras_valid   = (cnt_q != '0);
  assign ras_top     = ras_valid ? stack_q[top_idx] : '0;

  always_comb begin
    pc_next = pc_plus_inc;
    if (redirect)               pc_next = redirect_target;
    else if (jr)                pc_next = jr_target;
    else if (jal || jump)       pc_next = jump_target;
    else if (branch_taken)      pc_next = branch_target;
  end

  // JR wins over a simultaneous JAL, and a redirect leaves the stack untouched.
  assign do_push = pc_en && !redirect && !jr && jal;
  assign do_pop  = pc_en && !redirect && jr && ras_valid;

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    mis_d = 1'b0;
    if (pc_en) pc_d = pc_next;
    if (do_push) begin
      sp_d = sp_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
      mis_d = (ras_top != jr_target);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      if (do_push) stack_q[sp_q] <= pc_plus_inc;
    end
  end

  assign pc_curr        = pc_q;
  assign ras_count      = cnt_q;
  assign ras_mispredict = mis_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: directed scenarios then random traffic against a queue-based stack model.
module tb_pc_ras_unit;

  logic        CLK = 1'b0;
  logic        nRST, pc_en, redirect, branch_taken, jump, jal, jr;
  logic [31:0] redirect_target, branch_target, jump_target, jr_target;
  logic [31:0] pc_curr, pc_next, pc_plus_inc, ras_top;
  logic        ras_valid, ras_mispredict;
  logic [2:0]  ras_count;

  always #5 CLK = ~CLK;

  pc_ras_unit dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en),
    .redirect(redirect), .redirect_target(redirect_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jal(jal), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .pc_curr(pc_curr), .pc_next(pc_next), .pc_plus_inc(pc_plus_inc),
    .ras_top(ras_top), .ras_valid(ras_valid), .ras_count(ras_count),
    .ras_mispredict(ras_mispredict)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        vld;
    logic [31:0] top;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: the stack is a plain queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis;
  bit          m_init = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  task automatic clr();
    nRST = 1'b1; pc_en = 1'b1; redirect = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; jal = 1'b0; jr = 1'b0;
    redirect_target = '0; branch_target = '0; jump_target = '0; jr_target = '0;
  endtask

  // Called just after a falling edge with inputs driven; checks the combinational
  // outputs, advances the model, queues the expected post-edge state.
  task automatic tick();
    logic [31:0] plus, nxt;
    bit          pop, push;
    exp_t        e;
    #1;
    plus = m_pc + 32'd4;
    if (redirect)           nxt = redirect_target;
    else if (jr)            nxt = jr_target;
    else if (jal || jump)   nxt = jump_target;
    else if (branch_taken)  nxt = branch_target;
    else                    nxt = plus;
    if (m_init) begin
      check("pc_plus_inc", pc_plus_inc, plus);
      check("pc_next", pc_next, nxt);
      check("ras_top_comb", ras_top, m_top());
    end
    if (!nRST) begin
      m_pc = 32'h0; m_ras.delete(); m_mis = 1'b0; m_init = 1;
    end else if (pc_en) begin
      pop   = !redirect && jr && (m_ras.size() != 0);
      push  = !redirect && !jr && jal;
      m_mis = pop && (m_top() != jr_target);
      if (pop) void'(m_ras.pop_back());
      if (push) begin
        m_ras.push_back(plus);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc = nxt;
    end else begin
      m_mis = 1'b0;
    end
    if (m_init) begin
      e.pc  = m_pc;
      e.cnt = 3'(m_ras.size());
      e.vld = (m_ras.size() != 0);
      e.top = m_top();
      e.mis = m_mis;
      exp_q.push_back(e);
    end
    @(negedge CLK);
  endtask

  // Monitor: each rising edge produces one registered state to compare.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pc_curr", pc_curr, e.pc);
      check("ras_count", {29'h0, ras_count}, {29'h0, e.cnt});
      check("ras_valid", {31'h0, ras_valid}, {31'h0, e.vld});
      check("ras_top", ras_top, e.top);
      check("ras_mispredict", {31'h0, ras_mispredict}, {31'h0, e.mis});
    end
  end

  initial begin
    int drain;
    clr();
    @(negedge CLK);
    // reset then sequential advance
    nRST = 1'b0; tick(); tick();
    clr(); repeat (3) tick();
    // jal from 0x100 then matching jr
    clr(); redirect = 1'b1; redirect_target = 32'h100; tick();
    clr(); jal = 1'b1; jump_target = 32'h400; tick();
    clr(); jr = 1'b1; jr_target = 32'h104; tick();
    // five pushes overflow a four-deep stack, then drain it plus one empty pop
    for (int i = 0; i < 5; i++) begin
      clr(); jal = 1'b1; jump_target = 32'h1000 + 32'(i) * 32'h100; tick();
    end
    for (int i = 0; i < 5; i++) begin
      clr(); jr = 1'b1; jr_target = (i == 1) ? 32'hdead_0000 : m_top(); tick();
    end
    // redirect overrides jr and branch, stack untouched
    clr(); jal = 1'b1; jump_target = 32'h2000; tick();
    clr(); redirect = 1'b1; redirect_target = 32'h3000; jr = 1'b1; jr_target = 32'h44;
    branch_taken = 1'b1; branch_target = 32'h55; tick();
    // stall with jal, jr and jal together, then jr on empty
    clr(); pc_en = 1'b0; jal = 1'b1; jump_target = 32'h6000; tick();
    clr(); jr = 1'b1; jal = 1'b1; jump_target = 32'h7000; jr_target = 32'h8000; tick();
    clr(); jr = 1'b1; jr_target = 32'h9000; tick();
    clr(); jump = 1'b1; jump_target = 32'ha000; branch_taken = 1'b1; branch_target = 32'hb000; tick();
    // wrap and reset during jal
    clr(); redirect = 1'b1; redirect_target = 32'hffff_fffc; tick();
    clr(); tick();
    clr(); jal = 1'b1; jump_target = 32'hc000; tick();
    clr(); nRST = 1'b0; jal = 1'b1; jump_target = 32'hd000; tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      clr();
      nRST            = ($urandom_range(0, 49) != 0);
      pc_en           = ($urandom_range(0, 7) != 0);
      redirect        = ($urandom_range(0, 15) == 0);
      jr              = ($urandom_range(0, 5) == 0);
      jal             = ($urandom_range(0, 4) == 0);
      jump            = ($urandom_range(0, 7) == 0);
      branch_taken    = ($urandom_range(0, 5) == 0);
      redirect_target = $urandom() & 32'hffff_fffc;
      branch_target   = $urandom() & 32'hffff_fffc;
      jump_target     = $urandom() & 32'hffff_fffc;
      jr_target       = $urandom_range(0, 1) ? m_top() : ($urandom() & 32'hffff_fffc);
      tick();
    end
    clr();
    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(negedge CLK);
      drain++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected states left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
